init_sequencer: RTL and testbench

- Parametrised power-on/start sequencer for the ALU datapath; next generation of the fixed init block.
- On a start request:
  - asserts the datapath reset for a programmable number of cycles, then waits a settle interval;
  - drives an N-phase one-hot clock-enable rotation, with rising/falling-phase strobes, until the last mux stage reports completion.
- Adds round counting, timeout/error detection and restart; the fixed block has none of these.

---
 rtl/init_sequencer.sv | 152 +++++++++++++++
 tb/tb_init_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/init_sequencer.sv
// Start sequencer: holds the datapath in reset, settles, then rotates one-hot phase enables
// until the last mux stage reports completion or the round budget runs out.
module init_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int NPHASE        = 4,
  parameter int MAX_ROUNDS    = 8,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on,
  input  logic              muxlast,
  output logic              rstsig,
  output logic [NPHASE-1:0] phase_en,
  output logic              reclk,
  output logic              feclk,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  round_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_SETTLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SET_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  MAX_R    = CNT_W'(MAX_ROUNDS);
  localparam logic [NPHASE-1:0] PH_FIRST = NPHASE'(1);

  state_t              state_q, state_d;
  logic                on_q;
  logic                start_q, start_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    round_q, round_d;
  logic [CNT_W-1:0]    round_inc;
  logic [NPHASE-1:0]   phase_q, phase_d;
  logic [NPHASE-1:0]   phase_rot;
  logic                rstsig_q, rstsig_d;
  logic                reclk_q, reclk_d;
  logic                feclk_q, feclk_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    phase_d   = phase_q;
    err_d     = err_q;
    phase_rot = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
    round_inc = (round_q < MAX_R) ? round_q + CNT_W'(1) : round_q;
    // Starts are qualified at detection time, so an edge seen during DONE is dropped.
    start_d   = on & ~on_q & ((state_q == S_IDLE) || (state_q == S_ERR));

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_q) begin
          state_d = S_RESET;
          cnt_d   = '0;
          round_d = '0;
          err_d   = 1'b0;
        end
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          cnt_d = '0;
          if (SETTLE_CYCLES == 0) begin
            state_d = S_RUN;
            phase_d = PH_FIRST;
          end else begin
            state_d = S_SETTLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
          phase_d = PH_FIRST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        phase_d = phase_rot;
        if (phase_q[NPHASE-1]) begin
          round_d = round_inc;
          if (muxlast) begin
            state_d = S_DONE;
            phase_d = '0;
          end else if (round_inc >= MAX_R) begin
            state_d = S_ERR;
            phase_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rstsig_d = (state_d == S_RESET);
    busy_d   = (state_d == S_RESET) || (state_d == S_SETTLE) || (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    reclk_d  = phase_d[0];
    feclk_d  = phase_d[NPHASE/2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      on_q     <= 1'b0;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      round_q  <= '0;
      phase_q  <= '0;
      rstsig_q <= 1'b0;
      reclk_q  <= 1'b0;
      feclk_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      on_q     <= on;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      round_q  <= round_d;
      phase_q  <= phase_d;
      rstsig_q <= rstsig_d;
      reclk_q  <= reclk_d;
      feclk_q  <= feclk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rstsig    = rstsig_q;
  assign phase_en  = phase_q;
  assign reclk     = reclk_q;
  assign feclk     = feclk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign round_cnt = round_q;

endmodule

// File: tb/tb_init_sequencer.sv
// Scoreboard bench for init_sequencer: default config plus a SETTLE=0, NPHASE=2 variant.
module tb_init_sequencer;

  localparam int RST0 = 4, SET0 = 2, NPH0 = 4, MAX0 = 8;
  localparam int RST1 = 2, SET1 = 0, NPH1 = 2, MAX1 = 3;

  typedef logic [17:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       on0, mux0, on1, mux1;
  logic       rstsig0, reclk0, feclk0, busy0, done0, err0;
  logic       rstsig1, reclk1, feclk1, busy1, done1, err1;
  logic [3:0] phase0;
  logic [1:0] phase1;
  logic [7:0] round0, round1;

  vec_t q0[$];
  vec_t q1[$];
  vec_t e0, e1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  init_sequencer #(.RST_CYCLES(RST0), .SETTLE_CYCLES(SET0), .NPHASE(NPH0), .MAX_ROUNDS(MAX0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .on(on0), .muxlast(mux0), .rstsig(rstsig0), .phase_en(phase0),
    .reclk(reclk0), .feclk(feclk0), .busy(busy0), .done(done0), .err(err0), .round_cnt(round0));

  init_sequencer #(.RST_CYCLES(RST1), .SETTLE_CYCLES(SET1), .NPHASE(NPH1), .MAX_ROUNDS(MAX1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .on(on1), .muxlast(mux1), .rstsig(rstsig1), .phase_en(phase1),
    .reclk(reclk1), .feclk(feclk1), .busy(busy1), .done(done1), .err(err1), .round_cnt(round1));

  wire vec_t act0 = {rstsig0, phase0, reclk0, feclk0, busy0, done0, err0, round0};
  wire vec_t act1 = {rstsig1, 2'b00, phase1, reclk1, feclk1, busy1, done1, err1, round1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit r, input logic [3:0] ph, input int nph,
                              input bit b, input bit d, input bit e, input int rc);
    return {r, ph, ph[0], ph[nph/2], b, d, e, 8'(rc)};
  endfunction

  // Expected visible cycles of one sequence, from the first rstsig cycle to the done pulse.
  task automatic model(input int which, input int rstc, input int setc, input int nph,
                       input int maxr, input int k);
    int nr;
    vec_t v[$];
    nr = (k <= maxr) ? k : maxr;
    for (int t = 0; t < rstc; t++) v.push_back(mk(1'b1, 4'b0, nph, 1'b1, 1'b0, 1'b0, 0));
    for (int t = 0; t < setc; t++) v.push_back(mk(1'b0, 4'b0, nph, 1'b1, 1'b0, 1'b0, 0));
    for (int i = 0; i < nr * nph; i++)
      v.push_back(mk(1'b0, 4'(1 << (i % nph)), nph, 1'b1, 1'b0, 1'b0, i / nph));
    if (k <= maxr) v.push_back(mk(1'b0, 4'b0, nph, 1'b0, 1'b1, 1'b0, k));
    foreach (v[j]) begin
      if (which == 0) q0.push_back(v[j]);
      else            q1.push_back(v[j]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rstsig0 | busy0 | done0) begin
        if (q0.size() == 0) check("dut0_unexpected_activity", {rstsig0, busy0, done0}, 0);
        else begin
          e0 = q0.pop_front();
          check("dut0_trace", act0, e0);
        end
      end
      if (rstsig1 | busy1 | done1) begin
        if (q1.size() == 0) check("dut1_unexpected_activity", {rstsig1, busy1, done1}, 0);
        else begin
          e1 = q1.pop_front();
          check("dut1_trace", act1, e1);
        end
      end
    end
  end

  // Drives one start; muxlast is asserted at the last phase of round k only (k > maxr never),
  // with random noise on every other cycle unless mux_all holds it high throughout.
  // Entered and left at #1 after a rising edge.
  task automatic drive(input int which, input int rstc, input int setc, input int nph,
                       input int maxr, input int k, input bit mux_all, input int on_len);
    int nr, base, len, i;
    bit m;
    nr   = (k <= maxr) ? k : maxr;
    base = 1 + rstc + setc;
    len  = base + nr * nph + 3;
    model(which, rstc, setc, nph, maxr, k);
    for (int t = -1; t < len; t++) begin
      i = t - base;
      if (mux_all) m = 1'b1;
      else if (i >= 0 && (i % nph) == nph - 1) m = ((i / nph) + 1 == k);
      else m = 1'($urandom_range(0, 1));
      if (which == 0) begin on0 = (t + 1 < on_len); mux0 = m; end
      else            begin on1 = (t + 1 < on_len); mux1 = m; end
      @(posedge clk); #1;
    end
    if (which == 0) mux0 = 1'b0; else mux1 = 1'b0;
    check(which == 0 ? "dut0_queue_drained" : "dut1_queue_drained",
          which == 0 ? q0.size() : q1.size(), 0);
  endtask

  task automatic post(input int which, input int k, input int maxr);
    int nr;
    nr = (k <= maxr) ? k : maxr;
    if (which == 0) begin
      check("dut0_final_err",   err0,   (k > maxr));
      check("dut0_final_round", round0, nr);
      check("dut0_final_phase", phase0, 0);
      check("dut0_final_busy",  busy0,  0);
    end else begin
      check("dut1_final_err",   err1,   (k > maxr));
      check("dut1_final_round", round1, nr);
      check("dut1_final_phase", phase1, 0);
      check("dut1_final_busy",  busy1,  0);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1; on0 = 1'b0; mux0 = 1'b0; on1 = 1'b0; mux1 = 1'b0;
    #2;
    check("reset_outputs_dut0", act0, 0);
    check("reset_outputs_dut1", act1, 0);
    gap(2);
    rst = 1'b0;
    gap(2);

    // Single-cycle pulse with muxlast held high: done after the first round.
    drive(0, RST0, SET0, NPH0, MAX0, 1, 1'b1, 1);
    post(0, 1, MAX0);
    gap(3);

    // muxlast never set at a round end: timeout after MAX0 rounds, then restart from ERR.
    drive(0, RST0, SET0, NPH0, MAX0, MAX0 + 1, 1'b0, 1);
    post(0, MAX0 + 1, MAX0);
    gap(3);
    drive(0, RST0, SET0, NPH0, MAX0, 2, 1'b0, 2);
    post(0, 2, MAX0);
    gap(3);

    // on held for 100 cycles: exactly one sequence, done after round 3.
    drive(0, RST0, SET0, NPH0, MAX0, 3, 1'b0, 100);
    post(0, 3, MAX0);
    gap(80);
    on0 = 1'b0;
    check("held_on_no_restart_q", q0.size(), 0);
    gap(3);

    // Reset mid-RUN at phase 0100: outputs clear at once and nothing follows.
    model(0, RST0, SET0, NPH0, MAX0, 2);
    for (int t = -1; t < RST0 + SET0 + 3; t++) begin
      on0 = (t < 0);
      mux0 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    mux0 = 1'b0;
    check("pre_rst_phase", phase0, 4'b0100);
    rst = 1'b1;
    #1;
    check("midrun_rst_outputs", act0, 0);
    q0.delete();
    gap(2);
    rst = 1'b0;
    gap(20);
    check("after_rst_idle_done", done0, 0);
    check("after_rst_idle_busy", busy0, 0);

    // Second configuration: no settle, two phases.
    drive(1, RST1, SET1, NPH1, MAX1, 2, 1'b0, 1);
    post(1, 2, MAX1);
    gap(3);
    drive(1, RST1, SET1, NPH1, MAX1, MAX1 + 1, 1'b0, 3);
    post(1, MAX1 + 1, MAX1);
    gap(3);

    // Randomized runs, including restarts out of ERR.
    for (int n = 0; n < 10; n++) begin
      k = $urandom_range(1, MAX0 + 1);
      drive(0, RST0, SET0, NPH0, MAX0, k, 1'b0, $urandom_range(1, 3));
      post(0, k, MAX0);
      gap($urandom_range(1, 4));
    end
    for (int n = 0; n < 4; n++) begin
      k = $urandom_range(1, MAX1 + 1);
      drive(1, RST1, SET1, NPH1, MAX1, k, 1'b0, $urandom_range(1, 3));
      post(1, k, MAX1);
      gap($urandom_range(1, 4));
    end

    gap(5);
    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
